// File: rtl/dvs_bias_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dvs_bias_pkg
// Description : Shared bias word type, loader FSM encoding and array size
//               used by the regfile and the bias chain loader.
// Revision    : 1.0 - initial release
// ============================================================================
package dvs_bias_pkg;

    localparam int BIAS_WIDTH      = 24;
    localparam int NUM_BIASES_DFLT = 4;

    typedef logic [BIAS_WIDTH-1:0] bias_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/bias_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : bias_sclk_gen
// Description : CLK_DIV half-period divider for the bias chain shift clock;
//               gives the current phase plus half-period and bit-end strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module bias_sclk_gen
    import dvs_bias_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_phase_hi,
    output logic o_half_end,
    output logic o_bit_end
);

    localparam int                 c_cnt_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_div_cnt;
    logic               r_phase;
    logic               w_half_end;

    assign w_half_end = i_en && (r_div_cnt == c_cnt_last);

    // Disabled divider parks at the start of a low phase so every load
    // begins with a full-length low half.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_div_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (r_div_cnt == c_cnt_last) begin
            r_div_cnt <= '0;
            r_phase   <= ~r_phase;
        end else begin
            r_div_cnt <= r_div_cnt + c_cnt_w'(1);
        end
    end

    assign o_phase_hi = r_phase;
    assign o_half_end = w_half_end;
    assign o_bit_end  = w_half_end && r_phase;

endmodule
`default_nettype wire

// File: rtl/bias_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : bias_chain_loader
// Description : Serialises the bias word snapshot into the analog bias shift
//               chain and strobes latch. Optional periodic scrub reload is
//               enabled with `BIAS_LOADER_REFRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bias_chain_loader
    import dvs_bias_pkg::*;
#(
    parameter int NUM_BIASES  = NUM_BIASES_DFLT,
    parameter int CLK_DIV     = 2
`ifdef BIAS_LOADER_REFRESH_EN
    ,
    parameter int REFRESH_CYC = 2**20
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  bias_word_t [NUM_BIASES-1:0] bias_i,
    input  logic                        load_req,
    output logic                        busy,
    output logic                        done,
    output logic                        bias_sclk,
    output logic                        bias_sdata,
    output logic                        bias_latch,
    output logic [7:0]                  load_count
);

    localparam int                 c_n        = NUM_BIASES * BIAS_WIDTH;
    localparam int                 c_bit_w    = $clog2(c_n + 1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(c_n - 1);

    loader_state_e               r_state;
    loader_state_e               w_state_nxt;
    bias_word_t [NUM_BIASES-1:0] r_shadow;
    logic [c_n-1:0]              w_stream;
    logic [c_bit_w-1:0]          r_bitcnt;
    logic [c_bit_w-1:0]          w_bit_idx;
    logic                        r_pending;
    logic [7:0]                  r_load_count;
    logic                        w_refresh;
    logic                        w_trigger;
    logic                        w_start;
    logic                        w_last_bit;
    logic                        w_div_en;
    logic                        w_phase_hi;
    logic                        w_half_end;
    logic                        w_bit_end;

    // Word NUM_BIASES-1 sits in the top bits, so walking the flattened
    // snapshot from its MSB down gives the required chain order.
    assign w_stream   = r_shadow;
    assign w_bit_idx  = c_last_bit - r_bitcnt;
    assign w_last_bit = (r_bitcnt == c_last_bit);

    assign w_trigger  = load_req || (bias_i != r_shadow) || r_pending || w_refresh;
    assign w_start    = (r_state == IDLE) && w_trigger;
    assign w_div_en   = (r_state == SHIFT) || (r_state == LATCH);

    bias_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_div_en),
        .o_phase_hi (w_phase_hi),
        .o_half_end (w_half_end),
        .o_bit_end  (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        bias_sclk   = 1'b0;
        bias_sdata  = 1'b0;
        bias_latch  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                bias_sclk  = w_phase_hi;
                bias_sdata = w_stream[w_bit_idx];
                if (w_bit_end && w_last_bit) begin
                    w_state_nxt = LATCH;
                end
            end
            LATCH: begin
                busy       = 1'b1;
                bias_latch = 1'b1;
                if (w_half_end) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Requests arriving mid-load collapse into a single follow-up load;
    // bias edits need no flag because IDLE re-compares against the snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow     <= '0;
            r_bitcnt     <= '0;
            r_pending    <= 1'b0;
            r_load_count <= '0;
        end else begin
            if (w_start) begin
                r_shadow  <= bias_i;
                r_bitcnt  <= '0;
                r_pending <= 1'b0;
            end else begin
                if ((r_state != IDLE) && load_req) begin
                    r_pending <= 1'b1;
                end
                if ((r_state == SHIFT) && w_bit_end && !w_last_bit) begin
                    r_bitcnt <= r_bitcnt + c_bit_w'(1);
                end
            end
            if (r_state == DONE) begin
                r_load_count <= r_load_count + 8'd1;
            end
        end
    end

    assign load_count = r_load_count;

`ifdef BIAS_LOADER_REFRESH_EN
    localparam int                  c_idle_w    = $clog2(REFRESH_CYC + 1);
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(REFRESH_CYC - 1);

    logic [c_idle_w-1:0] r_idle_cnt;

    // Scrub reload after REFRESH_CYC quiet IDLE cycles guards the analog
    // chain against upsets and leakage.
    always_ff @(posedge clk) begin
        if (rst || (r_state != IDLE) || w_start) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + c_idle_w'(1);
        end
    end

    assign w_refresh = (r_state == IDLE) && (r_idle_cnt == c_idle_last);
`else
    assign w_refresh = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bias_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bias_chain_loader
// Description : Self-checking bench for bias_chain_loader: vector table,
//               corner-case sequences and random traffic vs. a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bias_chain_loader;
    import dvs_bias_pkg::*;

    localparam int NB        = 4;
    localparam int CD        = 2;
    localparam int BW        = 24;
    localparam int N         = NB * BW;
    localparam int SHIFT_CYC = N * 2 * CD;
    localparam int LOAD_CYC  = SHIFT_CYC + CD + 1;
`ifdef BIAS_LOADER_REFRESH_EN
    localparam int REFRESH   = 1000;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                load_req;
    bias_word_t [NB-1:0] bias_i;
    logic                busy, done, bias_sclk, bias_sdata, bias_latch;
    logic [7:0]          load_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] chain = '0;
    logic [N-1:0] latched[$];

    always #5 clk = ~clk;

    bias_chain_loader #(
        .NUM_BIASES  (NB),
        .CLK_DIV     (CD)
`ifdef BIAS_LOADER_REFRESH_EN
        ,
        .REFRESH_CYC (REFRESH)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bias_i     (bias_i),
        .load_req   (load_req),
        .busy       (busy),
        .done       (done),
        .bias_sclk  (bias_sclk),
        .bias_sdata (bias_sdata),
        .bias_latch (bias_latch),
        .load_count (load_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model of the analog chain: shifts on sclk rise, captures on latch rise.
    initial forever begin
        @(posedge bias_sclk);
        chain = {chain[N-2:0], bias_sdata};
    end
    initial forever begin
        @(posedge bias_latch);
        latched.push_back(chain);
    end

    // Inputs as seen by the active edge.
    logic                p_rst, p_req;
    bias_word_t [NB-1:0] p_bias;
    initial forever begin
        @(posedge clk);
        p_rst  = rst;
        p_req  = load_req;
        p_bias = bias_i;
    end

    // Reference model: a load is a fixed LOAD_CYC-cycle window; outputs are
    // derived arithmetically from the position inside that window.
    initial begin
        int           rem, cnt, idle, j;
        bit           pend, valid, trig;
        logic [N-1:0] shadow;
        logic         e_busy, e_done, e_latch, e_sclk, e_sdata;
        rem = 0; cnt = 0; idle = 0; pend = 0; valid = 0; shadow = '0;
        forever begin
            @(negedge clk);
            if (p_rst === 1'b1) begin
                rem = 0; cnt = 0; idle = 0; pend = 0; shadow = '0; valid = 1;
            end else if (valid) begin
                if (rem == 0) begin
                    trig = p_req || (p_bias != shadow) || pend;
`ifdef BIAS_LOADER_REFRESH_EN
                    if (!trig) begin
                        idle++;
                        if (idle >= REFRESH) trig = 1;
                    end
`endif
                    if (trig) begin
                        shadow = p_bias;
                        pend   = 0;
                        idle   = 0;
                        rem    = LOAD_CYC;
                    end
                end else begin
                    if (p_req) pend = 1;
                    if (rem == 1) cnt = (cnt + 1) % 256;
                    rem--;
                end
            end
            if (valid) begin
                j       = LOAD_CYC - rem;
                e_busy  = (rem != 0);
                e_done  = (rem == 1);
                e_latch = (rem != 0) && (j >= SHIFT_CYC) && (j < SHIFT_CYC + CD);
                e_sclk  = (rem != 0) && (j < SHIFT_CYC) && ((j % (2 * CD)) >= CD);
                e_sdata = (rem != 0) && (j < SHIFT_CYC) && shadow[N - 1 - j / (2 * CD)];
                check("cycle", {busy, done, bias_latch, bias_sclk, bias_sdata, load_count},
                      {e_busy, e_done, e_latch, e_sclk, e_sdata, 8'(cnt)});
            end
        end
    end

    typedef struct {
        bias_word_t   w[NB];
        bit           req;
        logic [N-1:0] exp_stream;
        int           exp_count;
    } vec_t;

    task automatic observe(input int ncyc, output int dones, output int gap, output int busy_cyc);
        dones = 0; gap = 0; busy_cyc = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            load_req = 1'b0;
            if (done) dones++;
            if (busy) busy_cyc++;
            else if (dones == 1) gap++;
        end
    endtask

    function automatic logic [N-1:0] last_latched();
        if (latched.size() == 0) return '0;
        return latched[latched.size() - 1];
    endfunction

    initial begin
        vec_t         vec[4];
        int           k, fb, d, g, b, nl0;
        logic [N-1:0] exp_s;

        vec[0] = '{w: '{24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD}, req: 1'b0,
                   exp_stream: 96'hDDDDDD_CCCCCC_BBBBBB_AAAAAA, exp_count: 1};
        vec[1] = '{w: '{24'h000001, 24'h800000, 24'hFFFFFF, 24'h000000}, req: 1'b0,
                   exp_stream: 96'h000000_FFFFFF_800000_000001, exp_count: 2};
        vec[2] = '{w: '{24'h123456, 24'hABCDEF, 24'h0F0F0F, 24'hF0F0F0}, req: 1'b0,
                   exp_stream: 96'hF0F0F0_0F0F0F_ABCDEF_123456, exp_count: 3};
        vec[3] = '{w: '{24'h123456, 24'hABCDEF, 24'h0F0F0F, 24'hF0F0F0}, req: 1'b1,
                   exp_stream: 96'hF0F0F0_0F0F0F_ABCDEF_123456, exp_count: 4};

        rst = 1'b1; load_req = 1'b0; bias_i = '0;
        repeat (3) @(negedge clk);
        check("reset", {busy, done, bias_latch, bias_sclk, bias_sdata, load_count}, '0);

        // Vector table; entry 0 is the power-up auto-load on reset release.
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < NB; w++) bias_i[w] = vec[i].w[w];
            load_req = vec[i].req;
            rst = 1'b0;
            k = 0; fb = 0;
            do begin
                @(negedge clk);
                load_req = 1'b0;
                k++;
                if (busy && fb == 0) fb = k;
            end while (!done && k < LOAD_CYC + 20);
            check("busy_rise", fb, 1);
            check("latency", k, 1 + SHIFT_CYC + CD);
            check("n_latch", latched.size(), i + 1);
            check("stream", last_latched(), vec[i].exp_stream);
            @(negedge clk);
            check("load_count", load_count, vec[i].exp_count);
        end

        // Bias word 1 rewritten at bit 40 of an in-flight load.
        nl0 = latched.size();
        load_req = 1'b1;
        for (int c = 0; c < 1 + 40 * 2 * CD; c++) begin
            @(negedge clk);
            load_req = 1'b0;
        end
        bias_i[1] = 24'h123456;
        observe(3 * LOAD_CYC, d, g, b);
        check("midwrite_dones", d, 2);
        check("midwrite_gap", g, 1);
        check("midwrite_n", latched.size() - nl0, 2);
        if (latched.size() >= nl0 + 2) begin
            check("midwrite_old", latched[nl0], 96'hF0F0F0_0F0F0F_ABCDEF_123456);
            check("midwrite_new", latched[nl0 + 1], 96'hF0F0F0_0F0F0F_123456_123456);
        end

        // Three requests during a load coalesce into one follow-up load.
        load_req = 1'b1;
        d = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            load_req = (c == 10 || c == 100 || c == 200);
            if (done) d++;
        end
        observe(3 * LOAD_CYC, k, g, b);
        check("coalesce_dones", d + k, 2);
        check("coalesce_gap", g, 1);

        // Reset asserted during bit 50.
        load_req = 1'b1;
        for (int c = 0; c < 1 + 50 * 2 * CD + 1; c++) begin
            @(negedge clk);
            load_req = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", {busy, done, bias_latch, bias_sclk, bias_sdata, load_count}, '0);
        rst = 1'b0;
        observe(LOAD_CYC + 10, d, g, b);
        check("rst_reload_dones", d, 1);
        check("rst_reload_stream", last_latched(), 96'hF0F0F0_0F0F0F_123456_123456);
        check("rst_reload_count", load_count, 1);

`ifdef BIAS_LOADER_REFRESH_EN
        // Scrub reloads: busy returns REFRESH+1 samples after each done.
        for (int r = 0; r < 2; r++) begin
            k = 0;
            while (busy && k < LOAD_CYC + 10) begin @(negedge clk); k++; end
            k = 1;
            while (!busy && k < REFRESH + 50) begin @(negedge clk); k++; end
            check("refresh_gap", k, REFRESH + 1);
            k = 0;
            while (!done && k < LOAD_CYC + 10) begin @(negedge clk); k++; end
        end
`else
        observe(10000, d, g, b);
        check("no_refresh_busy", b, 0);
`endif

        // Random traffic, cycle-checked by the model above.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            load_req = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) bias_i[$urandom_range(0, NB - 1)] = bias_word_t'($urandom);
        end
        @(negedge clk);
        load_req = 1'b0;
        k = 0;
        while (k < 3 * LOAD_CYC) begin
            @(negedge clk);
            k++;
            if (!busy) begin
                @(negedge clk);
                if (!busy) break;
            end
        end
        check("random_settle", busy, 1'b0);
        for (int w = 0; w < NB; w++) exp_s[w * BW +: BW] = bias_i[w];
        check("random_final_stream", last_latched(), exp_s);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
